// File: rtl/ng_mem_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : ng_mem_seq_if
//  Description : Request/response and external-memory bundle for the
//                ng_mem_seq memory-cycle sequencer.
//                slave  - the sequencer side.
//                master - the requester plus the memory model
//                         (drives requests and MEM_RDATA).
//                Signals:
//                  ADDRESS[13:0]   resolved {BANK, S[9:0]} from decode
//                  RD_REQ, WR_REQ  single-cycle request pulses
//                  WR_DATA[15:0]   write data
//                  RD_DATA[15:0]   captured read data
//                  RD_VALID, WR_DONE, REG_HIT, WR_FAULT  completion pulses
//                  BUSY            sequencer not idle
//                  MEM_ADDR, MEM_WDATA, MEM_CS, MEM_WE, MEM_ROM  memory side
//                  MEM_RDATA[15:0] memory read data
//  Revision    : 1.0 - initial release
// ============================================================================
interface ng_mem_seq_if;
    logic [13:0] ADDRESS;
    logic        RD_REQ;
    logic        WR_REQ;
    logic [15:0] WR_DATA;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic        WR_DONE;
    logic        REG_HIT;
    logic        WR_FAULT;
    logic        BUSY;
    logic [13:0] MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        MEM_CS;
    logic        MEM_WE;
    logic        MEM_ROM;

    modport master (
        output ADDRESS, RD_REQ, WR_REQ, WR_DATA, MEM_RDATA,
        input  RD_DATA, RD_VALID, WR_DONE, REG_HIT, WR_FAULT, BUSY,
               MEM_ADDR, MEM_WDATA, MEM_CS, MEM_WE, MEM_ROM
    );

    modport slave (
        input  ADDRESS, RD_REQ, WR_REQ, WR_DATA, MEM_RDATA,
        output RD_DATA, RD_VALID, WR_DONE, REG_HIT, WR_FAULT, BUSY,
               MEM_ADDR, MEM_WDATA, MEM_CS, MEM_WE, MEM_ROM
    );
endinterface
`default_nettype wire

// File: rtl/ng_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : ng_mem_seq
//  Description : Memory-cycle sequencer. Accepts one read or write request
//                while idle, classifies it (central register / illegal
//                fixed-memory write / real access), runs a timed strobe to
//                erasable or fixed memory and reports completion with a
//                one-cycle pulse. Writes to octal 20-23 are edited
//                (CYR, SR, CYL, EDOP) before reaching memory.
//  Ports       : CLK2   - clock, all state changes on posedge
//                GENRST - synchronous active-high reset
//                bus    - ng_mem_seq_if.slave (request, response, memory)
//  Revision    : 1.0 - initial release
// ============================================================================
module ng_mem_seq #(
    parameter int          WAIT_STATES = 1,        // extra strobe cycles, 0..15
    parameter logic [13:0] ERASE_TOP   = 14'o1777, // last erasable address
    parameter logic [13:0] REG_TOP     = 14'o0017  // last central register
) (
    input  wire logic   CLK2,
    input  wire logic   GENRST,
    ng_mem_seq_if.slave bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    localparam logic [3:0] c_WS = 4'(WAIT_STATES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_is_wr;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_wr_done;
    logic        r_reg_hit;
    logic        r_wr_fault;
    logic [13:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_mem_cs;
    logic        r_mem_we;
    logic        r_mem_rom;

    logic        w_rd;
    logic        w_wr;
    logic        w_last;
    logic [14:0] w_x;
    logic [15:0] w_edit;

    // A simultaneous read and write services only the read.
    assign w_rd = bus.RD_REQ;
    assign w_wr = bus.WR_REQ & ~bus.RD_REQ;

    // Last cycle with the strobe asserted: SETUP when there are no wait
    // states, otherwise the STROBE cycle whose counter has run down to 1.
    assign w_last = ((r_state == c_SETUP) && (c_WS == 4'd0)) ||
                    ((r_state == c_STROBE) && (r_cnt == 4'd1));

    // Editing transforms work on the 15-bit word; bit 15 mirrors bit 14.
    always_comb begin
        w_x    = bus.WR_DATA[14:0];
        w_edit = bus.WR_DATA;
        case (bus.ADDRESS)
            14'o0020: w_edit = {w_x[0],  w_x[0],  w_x[14:1]};   // CYR
            14'o0021: w_edit = {w_x[14], w_x[14], w_x[14:1]};   // SR
            14'o0022: w_edit = {w_x[13], w_x[13:0], w_x[14]};   // CYL
            14'o0023: w_edit = {9'd0, w_x[14:8], w_x[7]};       // EDOP
            default:  w_edit = bus.WR_DATA;
        endcase
    end

    always_ff @(posedge CLK2) begin
        if (GENRST) begin
            r_state     <= c_IDLE;
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_rd_data   <= 16'd0;
            r_rd_valid  <= 1'b0;
            r_wr_done   <= 1'b0;
            r_reg_hit   <= 1'b0;
            r_wr_fault  <= 1'b0;
            r_mem_addr  <= 14'd0;
            r_mem_wdata <= 16'd0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_rom   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_reg_hit  <= 1'b0;
            r_wr_fault <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_mem_rom <= 1'b0;
                    if (w_rd || w_wr) begin
                        if (bus.ADDRESS <= REG_TOP) begin
                            r_reg_hit <= 1'b1;
                            r_state   <= c_DONE;
                        end else if (w_wr && (bus.ADDRESS > ERASE_TOP)) begin
                            r_wr_fault <= 1'b1;
                            r_state    <= c_DONE;
                        end else begin
                            r_mem_addr <= bus.ADDRESS;
                            r_mem_rom  <= (bus.ADDRESS > ERASE_TOP);
                            r_is_wr    <= w_wr;
                            if (w_wr) begin
                                r_mem_wdata <= w_edit;
                            end
                            r_mem_cs   <= 1'b1;
                            r_mem_we   <= w_wr;
                            r_state    <= c_SETUP;
                        end
                    end
                end
                c_SETUP: begin
                    r_cnt   <= c_WS;
                    r_state <= (c_WS == 4'd0) ? c_DONE : c_STROBE;
                end
                c_STROBE: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= c_DONE;
                    end
                end
                default: begin   // c_DONE
                    r_mem_rom <= 1'b0;
                    r_state   <= c_IDLE;
                end
            endcase

            // Close the strobe and report; read data is taken from the final
            // strobe cycle, where memory guarantees it is valid.
            if (w_last) begin
                r_mem_cs <= 1'b0;
                r_mem_we <= 1'b0;
                if (r_is_wr) begin
                    r_wr_done <= 1'b1;
                end else begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= bus.MEM_RDATA;
                end
            end
        end
    end

    assign bus.RD_DATA   = r_rd_data;
    assign bus.RD_VALID  = r_rd_valid;
    assign bus.WR_DONE   = r_wr_done;
    assign bus.REG_HIT   = r_reg_hit;
    assign bus.WR_FAULT  = r_wr_fault;
    assign bus.BUSY      = (r_state != c_IDLE);
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_WDATA = r_mem_wdata;
    assign bus.MEM_CS    = r_mem_cs;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_ROM   = r_mem_rom;

endmodule
`default_nettype wire
